// File: rtl/ppu_vga_scaler.sv
// ppu_vga_scaler: PPU frame buffer replayed at integer SCALE, centred in a VGA raster, two-stage pipeline.
// Define PPU_VGA_PALETTE_EN for a writable palette; otherwise a fixed grayscale ramp is used.
module ppu_vga_scaler #(
   parameter int SRC_W      = 256,
   parameter int SRC_H      = 240,
   parameter int PIX_BITS   = 2,
   parameter int COLOR_BITS = 4,
   parameter int SCALE      = 2,
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int X_OFFSET   = (H_VISIBLE - SRC_W * SCALE) / 2,
   parameter int Y_OFFSET   = (V_VISIBLE - SRC_H * SCALE) / 2,
   parameter logic [3*COLOR_BITS-1:0] BORDER_RGB = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ppu_we,
   input  logic [$clog2(SRC_W)-1:0]  ppu_x,
   input  logic [$clog2(SRC_H)-1:0]  ppu_y,
   input  logic [PIX_BITS-1:0]       ppu_pixel,
`ifdef PPU_VGA_PALETTE_EN
   input  logic                      pal_we,
   input  logic [PIX_BITS-1:0]       pal_idx,
   input  logic [3*COLOR_BITS-1:0]   pal_rgb,
`endif
   output logic [COLOR_BITS-1:0]     vga_r,
   output logic [COLOR_BITS-1:0]     vga_g,
   output logic [COLOR_BITS-1:0]     vga_b,
   output logic                      VGA_HS,
   output logic                      VGA_VS,
   output logic                      vga_de,
   output logic                      frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int NPIX    = SRC_W * SRC_H;
   localparam int AW      = $clog2(NPIX);
   localparam int XW      = $clog2(SRC_W) + 1;
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int CW      = 3 * COLOR_BITS;
   localparam int NPAL    = 2 ** PIX_BITS;

   function automatic logic [CW-1:0] ramp_rgb(input int idx);
      int c;
      c = idx * (2 ** COLOR_BITS - 1) / (2 ** PIX_BITS - 1);
      return {3{COLOR_BITS'(c)}};
   endfunction

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [SW-1:0] sx_sub_q, sx_sub_d, sy_sub_q, sy_sub_d;
   logic [XW-1:0] src_x_q, src_x_d;
   logic [AW-1:0] row_base_q, row_base_d;
   logic          h_wrap, h_win, v_win;
   logic [AW-1:0] rd_addr, wr_addr;
   logic          wr_en;
   logic          s1_vis_q, s1_vis_d, s1_win_q, s1_win_d, s1_hs_q, s1_hs_d;
   logic          s1_vs_q, s1_vs_d, s1_fs_q, s1_fs_d;
   logic [PIX_BITS-1:0] rd_data_q;
   logic [CW-1:0] lut_rgb, rgb_q, rgb_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
   logic [PIX_BITS-1:0] mem [NPIX];

   // Stage 0: raster counters and incremental source address (no multiplier on the read path).
   always_comb begin
      h_wrap  = (32'(h_cnt_q) == H_TOTAL - 1);
      h_win   = (32'(h_cnt_q) >= X_OFFSET) && (32'(h_cnt_q) < X_OFFSET + SRC_W * SCALE);
      v_win   = (32'(v_cnt_q) >= Y_OFFSET) && (32'(v_cnt_q) < Y_OFFSET + SRC_H * SCALE);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) v_cnt_d = (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);

      sx_sub_d = '0;
      src_x_d  = '0;
      if (h_win) begin
         if (32'(sx_sub_q) == SCALE - 1) begin
            src_x_d = src_x_q + XW'(1);
         end else begin
            sx_sub_d = sx_sub_q + SW'(1);
            src_x_d  = src_x_q;
         end
      end

      // Row base steps once per SCALE window lines and is cleared on every line outside the window.
      sy_sub_d   = sy_sub_q;
      row_base_d = row_base_q;
      if (h_wrap) begin
         if (!v_win) begin
            sy_sub_d   = '0;
            row_base_d = '0;
         end else if (32'(sy_sub_q) == SCALE - 1) begin
            sy_sub_d   = '0;
            row_base_d = row_base_q + AW'(SRC_W);
         end else begin
            sy_sub_d = sy_sub_q + SW'(1);
         end
      end

      rd_addr  = (h_win && v_win) ? row_base_q + AW'(src_x_q) : '0;
      wr_en    = ppu_we && (32'(ppu_x) < SRC_W) && (32'(ppu_y) < SRC_H);
      wr_addr  = AW'(32'(ppu_y) * SRC_W + 32'(ppu_x));

      s1_vis_d = (32'(h_cnt_q) < H_VISIBLE) && (32'(v_cnt_q) < V_VISIBLE);
      s1_win_d = h_win && v_win;
      s1_hs_d  = !((32'(h_cnt_q) >= H_VISIBLE + H_FP) && (32'(h_cnt_q) < H_VISIBLE + H_FP + H_SYNC));
      s1_vs_d  = !((32'(v_cnt_q) >= V_VISIBLE + V_FP) && (32'(v_cnt_q) < V_VISIBLE + V_FP + V_SYNC));
      s1_fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // Read-before-write: a same-address read in the write cycle returns the old pixel.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= ppu_pixel;
      rd_data_q <= mem[rd_addr];
   end

`ifdef PPU_VGA_PALETTE_EN
   logic [CW-1:0] pal_q [NPAL];
   logic [CW-1:0] pal_d [NPAL];

   always_comb begin
      for (int i = 0; i < NPAL; i++) pal_d[i] = pal_q[i];
      if (pal_we) pal_d[pal_idx] = pal_rgb;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NPAL; i++) pal_q[i] <= ramp_rgb(i);
      end else begin
         for (int i = 0; i < NPAL; i++) pal_q[i] <= pal_d[i];
      end
   end

   assign lut_rgb = pal_q[rd_data_q];
`else
   assign lut_rgb = ramp_rgb(int'(rd_data_q));
`endif

   always_comb begin
      rgb_d = '0;
      if (s1_vis_q) rgb_d = s1_win_q ? lut_rgb : BORDER_RGB;
      hs_d = s1_hs_q;
      vs_d = s1_vs_q;
      de_d = s1_vis_q;
      fs_d = s1_fs_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         sx_sub_q   <= '0;
         sy_sub_q   <= '0;
         src_x_q    <= '0;
         row_base_q <= '0;
         s1_vis_q   <= 1'b0;
         s1_win_q   <= 1'b0;
         s1_hs_q    <= 1'b1;
         s1_vs_q    <= 1'b1;
         s1_fs_q    <= 1'b0;
         rgb_q      <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         de_q       <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         sx_sub_q   <= sx_sub_d;
         sy_sub_q   <= sy_sub_d;
         src_x_q    <= src_x_d;
         row_base_q <= row_base_d;
         s1_vis_q   <= s1_vis_d;
         s1_win_q   <= s1_win_d;
         s1_hs_q    <= s1_hs_d;
         s1_vs_q    <= s1_vs_d;
         s1_fs_q    <= s1_fs_d;
         rgb_q      <= rgb_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         de_q       <= de_d;
         fs_q       <= fs_d;
      end
   end

   assign vga_r       = rgb_q[3*COLOR_BITS-1 -: COLOR_BITS];
   assign vga_g       = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
   assign vga_b       = rgb_q[COLOR_BITS-1:0];
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign vga_de      = de_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_ppu_vga_scaler.sv
// tb_ppu_vga_scaler: random frame-buffer writes on a reduced VGA mode, checked against a raster model.
// Pin expectations are derived from (h,v) = cycle position with plain division into the source image.
`timescale 1ns/1ps
module tb_ppu_vga_scaler;

   localparam int SRC_W = 12;
   localparam int SRC_H = 6;
   localparam int PB    = 2;
   localparam int CB    = 4;
   localparam int SCALE = 2;
   localparam int HV = 32, HFP = 2, HSY = 4, HBP = 3;
   localparam int VV = 16, VFP = 1, VSY = 2, VBP = 2;
   localparam int XO = (HV - SRC_W * SCALE) / 2;
   localparam int YO = (VV - SRC_H * SCALE) / 2;
   localparam int HT = HV + HFP + HSY + HBP;
   localparam int VT = VV + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam logic [3*CB-1:0] BORDER = 12'hF00;
   localparam int PW = 3 * CB + 4;
   localparam int EW = 2 + PB + 4;
   localparam logic [PW-1:0] RST_PINS = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ppu_we = 1'b0;
   logic [3:0]    ppu_x = '0;
   logic [2:0]    ppu_y = '0;
   logic [PB-1:0] ppu_pixel = '0;
`ifdef PPU_VGA_PALETTE_EN
   logic            pal_we = 1'b0;
   logic [PB-1:0]   pal_idx = '0;
   logic [3*CB-1:0] pal_rgb = '0;
   logic            pal_pend = 1'b0;
   logic [PB-1:0]   pal_pend_idx = '0;
   logic [3*CB-1:0] pal_pend_rgb = '0;
`endif
   logic [CB-1:0] vga_r, vga_g, vga_b;
   logic          VGA_HS, VGA_VS, vga_de, frame_start;
   logic [PW-1:0] pins;

   // Model state: frame buffer, palette, and expected-pin scoreboard {mode, idx, hs, vs, de, fs}.
   logic [PB-1:0]   fb [SRC_H][SRC_W];
   logic [3*CB-1:0] pal_m [2**PB];
   logic [EW-1:0]   exp_q [$];
   int m, last_fs, fs_seen;
   int n_total, n_bad;

   ppu_vga_scaler #(
      .SRC_W(SRC_W), .SRC_H(SRC_H), .PIX_BITS(PB), .COLOR_BITS(CB), .SCALE(SCALE),
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .X_OFFSET(XO), .Y_OFFSET(YO), .BORDER_RGB(BORDER)
   ) dut (
      .clk(clk), .rst(rst), .ppu_we(ppu_we), .ppu_x(ppu_x), .ppu_y(ppu_y), .ppu_pixel(ppu_pixel),
`ifdef PPU_VGA_PALETTE_EN
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
`endif
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .vga_de(vga_de), .frame_start(frame_start)
   );

   assign pins = {vga_r, vga_g, vga_b, VGA_HS, VGA_VS, vga_de, frame_start};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, m, got, want);
      end
   endtask

   function automatic logic [3*CB-1:0] ramp(input int idx);
      int c;
      c = idx * (2**CB - 1) / (2**PB - 1);
      return {CB'(c), CB'(c), CB'(c)};
   endfunction

   function automatic logic [EW-1:0] expect_state(input int k);
      int h, v;
      logic vis, win;
      logic [1:0] mode;
      logic [PB-1:0] idx;
      h = k % HT;
      v = (k / HT) % VT;
      vis = (h < HV) && (v < VV);
      win = (h >= XO) && (h < XO + SRC_W * SCALE) && (v >= YO) && (v < YO + SRC_H * SCALE);
      mode = 2'd0;
      idx = '0;
      if (vis && win) begin
         mode = 2'd2;
         idx = fb[(v - YO) / SCALE][(h - XO) / SCALE];
      end else if (vis) begin
         mode = 2'd1;
      end
      return {mode, idx, !(h >= HV + HFP && h < HV + HFP + HSY),
              !(v >= VV + VFP && v < VV + VFP + VSY), vis, (h == 0 && v == 0)};
   endfunction

   function automatic logic [PW-1:0] resolve(input logic [EW-1:0] e);
      logic [3*CB-1:0] c;
      case (e[EW-1 -: 2])
         2'd2:    c = pal_m[e[PB+3:4]];
         2'd1:    c = BORDER;
         default: c = '0;
      endcase
      return {c, e[3:0]};
   endfunction

   task automatic drive_write(input int x, input int y, input int d);
      ppu_we = 1'b1;
      ppu_x = 4'(x);
      ppu_y = 3'(y);
      ppu_pixel = PB'(d);
      if (x < SRC_W && y < SRC_H) fb[y][x] = PB'(d);
   endtask

   task automatic drive_random();
      if ($urandom_range(0, 3) != 0)
         drive_write($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3));
   endtask

`ifdef PPU_VGA_PALETTE_EN
   task automatic drive_pal(input int idx, input logic [3*CB-1:0] rgb);
      pal_we = 1'b1;
      pal_idx = PB'(idx);
      pal_rgb = rgb;
      pal_pend = 1'b1;
      pal_pend_idx = PB'(idx);
      pal_pend_rgb = rgb;
   endtask
`endif

   task automatic step();
      logic [EW-1:0] e;
      @(posedge clk);
      m++;
      @(negedge clk);
      exp_q.push_back(expect_state(m));
      if (m >= 2) begin
         e = exp_q.pop_front();
         check("pins", 32'(pins), 32'(resolve(e)));
      end else begin
         check("pipe_fill", 32'(pins), 32'(RST_PINS));
      end
      if (frame_start === 1'b1) begin
         if (last_fs >= 0) check("fs_period", m - last_fs, FRAME);
         last_fs = m;
         fs_seen++;
      end
`ifdef PPU_VGA_PALETTE_EN
      if (pal_pend) pal_m[pal_pend_idx] = pal_pend_rgb;
      pal_pend = 1'b0;
      pal_we = 1'b0;
`endif
      ppu_we = 1'b0;
   endtask

   task automatic release_reset();
      rst = 1'b0;
      m = 0;
      last_fs = -1;
      fs_seen = 0;
      exp_q.delete();
      for (int i = 0; i < 2**PB; i++) pal_m[i] = ramp(i);
      exp_q.push_back(expect_state(0));
   endtask

   task automatic check_fs_count();
      check("fs_count", fs_seen, (m >= 2) ? (m - 2) / FRAME + 1 : 0);
   endtask

   initial begin
      n_total = 0;
      n_bad = 0;
      m = 0;
      repeat (2) @(negedge clk);
      check("rst_hold", 32'(pins), 32'(RST_PINS));
      @(negedge clk);
      check("rst_hold", 32'(pins), 32'(RST_PINS));
      release_reset();

      // Fill the whole buffer during the lines above the image window.
      for (int y = 0; y < SRC_H; y++) begin
         for (int x = 0; x < SRC_W; x++) begin
            if (x == 0 && y == 0) drive_write(0, 0, 3);
            else if (x == SRC_W - 1 && y == SRC_H - 1) drive_write(x, y, 1);
            else drive_write(x, y, $urandom_range(0, 3));
            step();
         end
      end
      drive_write(12, 0, int'(~fb[1][0]));
      step();
      drive_write(3, 6, int'(~fb[0][3]));
      step();
      drive_write(15, 7, int'(~fb[0][0]));
      step();

      for (int i = 0; i < 3 * FRAME; i++) begin
         drive_random();
`ifdef PPU_VGA_PALETTE_EN
         if (i == FRAME + 17) drive_pal(2, 12'h0F0);
`endif
         step();
      end
      for (int i = 0; i < HT && (m % HT) != 15; i++) begin
         drive_random();
         step();
      end
      check_fs_count();

      // Asynchronous reset in the middle of an image line.
      #2 rst = 1'b1;
`ifdef PPU_VGA_PALETTE_EN
      pal_pend = 1'b0;
`endif
      #1 check("async_rst", 32'(pins), 32'(RST_PINS));
      @(negedge clk);
      check("rst_hold", 32'(pins), 32'(RST_PINS));
      release_reset();

      for (int i = 0; i < 2 * FRAME + 40; i++) begin
         drive_random();
         step();
      end
      check_fs_count();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
